// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with a double-buffered display word,
// per-slot dead time and optional leading-zero blanking.
module seg_scan_driver #(
  parameter int TICK_DIV = 100000,
  parameter int DEAD     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic [31:0] data_in,
  input  logic        page,
  input  logic        blank_lz,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam int            PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST   = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] DEAD_C = PW'(DEAD);

  logic [PW-1:0] prescaler;
  logic [1:0]    digit;
  logic [31:0]   shadow;
  logic [31:0]   display;
  logic          page_q;

  logic          tick;
  logic          boundary;
  logic [15:0]   half;
  logic [3:0]    nibble;
  logic          blanked;
  logic          lit;
  logic [3:0]    anode_next;
  logic [6:0]    seg_next;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign tick     = (prescaler == LAST);
  assign boundary = tick && (digit == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      digit     <= '0;
      shadow    <= '0;
      display   <= '0;
      page_q    <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick)
        digit <= digit + 2'd1;
      if (data_valid)
        shadow <= data_in;
      // NOTE: non-blocking assignments mean display samples shadow's value from
      // before this edge, so a capture on the boundary cycle waits a full frame.
      if (boundary) begin
        display <= shadow;
        page_q  <= page;
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    blanked    = 1'b0;
    half       = page_q ? display[31:16] : display[15:0];
    nibble     = half[{digit, 2'b00} +: 4];
    case (digit)
      2'd1:    blanked = blank_lz && (half[15:4]  == 12'h000);
      2'd2:    blanked = blank_lz && (half[15:8]  == 8'h00);
      2'd3:    blanked = blank_lz && (half[15:12] == 4'h0);
      default: blanked = 1'b0;
    endcase
    lit        = (prescaler >= DEAD_C) && !blanked;
    anode_next = lit ? ~(4'b0001 << digit) : 4'b1111;
    seg_next   = lit ? hex7(nibble) : 7'b1111111;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode      <= 4'b1111;
      seg        <= 7'b1111111;
      frame_done <= 1'b0;
    end else begin
      anode      <= anode_next;
      seg        <= seg_next;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a cycle-count based model checked every cycle,
// plus directed scenarios with hand-computed digit patterns.
module tb_seg_scan_driver;

  localparam int TICK_DIV = 8;
  localparam int DEAD     = 2;
  localparam int FRAME    = 4 * TICK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_valid = 1'b0;
  logic [31:0] data_in = '0;
  logic        page = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(.TICK_DIV(TICK_DIV), .DEAD(DEAD)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_in(data_in),
    .page(page), .blank_lz(blank_lz), .anode(anode), .seg(seg),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position in the scan is derived purely from the edge count since reset.
  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  int          m_n = 0;
  logic [31:0] m_shadow = '0;
  logic [31:0] m_disp = '0;
  logic        m_page = 1'b0;
  logic [3:0]  exp_anode = 4'b1111;
  logic [6:0]  exp_seg = 7'b1111111;
  logic        exp_fd = 1'b0;

  always @(posedge clk or posedge rst) begin
    int slot, phase;
    logic [15:0] half;
    logic blanked;
    if (rst) begin
      m_n = 0; m_shadow = '0; m_disp = '0; m_page = 1'b0;
      exp_anode = 4'b1111; exp_seg = 7'b1111111; exp_fd = 1'b0;
    end else begin
      slot    = (m_n / TICK_DIV) % 4;
      phase   = m_n % TICK_DIV;
      half    = m_page ? m_disp[31:16] : m_disp[15:0];
      blanked = blank_lz && (slot > 0) && ((half >> (4 * slot)) == 16'h0);
      if (phase >= DEAD && !blanked) begin
        exp_anode = 4'b1111 ^ (4'b0001 << slot);
        exp_seg   = hex_tab[4'(half >> (4 * slot))];
      end else begin
        exp_anode = 4'b1111;
        exp_seg   = 7'b1111111;
      end
      exp_fd = (m_n % FRAME) == FRAME - 1;
      if (exp_fd) begin
        m_disp = m_shadow;
        m_page = page;
      end
      if (data_valid) m_shadow = data_in;
      m_n++;
    end
  end

  always @(negedge clk) begin
    check("anode", 32'(anode), 32'(exp_anode));
    check("seg", 32'(seg), 32'(exp_seg));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    check("one_hot_anode", 32'($countones(~anode) <= 1), 32'd1);
  end

  task automatic wait_frame(input string name);
    logic found = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (frame_done) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic wait_digit(input int n, input logic [6:0] exp_code, input string name);
    logic found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (anode == (4'b1111 ^ (4'b0001 << n))) begin
        found = 1'b1;
        break;
      end
    end
    check({name, "_seen"}, 32'(found), 32'd1);
    check(name, 32'(seg), 32'(exp_code));
  endtask

  task automatic first_light(input string name);
    int cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt++;
      if (anode != 4'b1111) break;
    end
    check({name, "_delay"}, 32'(cnt), 32'(DEAD + 1));
    check({name, "_anode"}, 32'(anode), 32'b1110);
    check({name, "_seg"}, 32'(seg), 32'b1000000);
  endtask

  task automatic pulse_data(input logic [31:0] v);
    data_in    = v;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] seen;
    logic [6:0] seg0, seg1;
    int per;

    @(negedge clk);
    check("rst_anode", 32'(anode), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_fd", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    first_light("release");

    wait_frame("first_frame");
    per = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      per++;
      if (frame_done) break;
    end
    check("frame_period", 32'(per), 32'(FRAME));

    // 0x1234ABCD on page 0
    pulse_data(32'h1234ABCD);
    wait_frame("wf_data");
    wait_digit(0, 7'b0100001, "p0_d0_D");
    wait_digit(1, 7'b1000110, "p0_d1_C");
    wait_digit(2, 7'b0000011, "p0_d2_B");
    wait_digit(3, 7'b0001000, "p0_d3_A");

    // page switch mid-frame takes effect at the next frame
    wait_frame("wf_page");
    repeat (10) @(negedge clk);
    page = 1'b1;
    wait_digit(3, 7'b0001000, "page_hold_d3_A");
    wait_frame("wf_page1");
    wait_digit(0, 7'b0011001, "p1_d0_4");
    wait_digit(1, 7'b0110000, "p1_d1_3");
    wait_digit(2, 7'b0100100, "p1_d2_2");
    wait_digit(3, 7'b1111001, "p1_d3_1");

    // leading-zero blanking of 0x000000F0
    page = 1'b0;
    blank_lz = 1'b1;
    pulse_data(32'h000000F0);
    wait_frame("wf_blank");
    wait_frame("wf_blank2");
    seen = '0; seg0 = '1; seg1 = '1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      seen |= ~anode;
      if (anode == 4'b1110) seg0 = seg;
      if (anode == 4'b1101) seg1 = seg;
    end
    check("blank_seen", 32'(seen), 32'b0011);
    check("blank_d0_0", 32'(seg0), 32'b1000000);
    check("blank_d1_F", 32'(seg1), 32'b0001110);
    blank_lz = 1'b0;
    wait_frame("wf_noblank");
    seen = '0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      seen |= ~anode;
    end
    check("noblank_seen", 32'(seen), 32'b1111);

    // capture exactly on the boundary cycle: old value holds one more frame
    wait_frame("wf_bnd");
    repeat (FRAME - 1) @(negedge clk);
    data_in    = 32'h00005678;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check("fd_on_boundary", 32'(frame_done), 32'd1);
    wait_digit(1, 7'b0001110, "bnd_old_d1_F");
    wait_frame("wf_bnd_new");
    wait_digit(0, 7'b0000000, "bnd_new_d0_8");
    wait_digit(1, 7'b1111000, "bnd_new_d1_7");

    // asynchronous reset during the digit 2 slot
    wait_digit(2, 7'b0000010, "pre_rst_d2_6");
    #1 rst = 1'b1;
    #1;
    check("async_rst_anode", 32'(anode), 32'hF);
    check("async_rst_seg", 32'(seg), 32'h7F);
    check("async_rst_fd", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    first_light("restart");
    wait_digit(1, 7'b1000000, "restart_d1_0");

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
